// File: rtl/dmac_axi_writer_if.sv
// Bundle of command, data-buffer, AXI write-channel and completion signals
// between the DMA write engine (master) and its environment (slave).
interface dmac_axi_writer_if #(
  parameter int ADDR_WD = 32,
  parameter int DATA_WD = 32
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [ADDR_WD-1:0]   cmd_dst_addr;
  logic [ADDR_WD-1:0]   cmd_len;
  logic                 data_valid;
  logic                 data_ready;
  logic [DATA_WD-1:0]   data;
  logic                 data_last;
  logic                 awvalid;
  logic                 awready;
  logic [ADDR_WD-1:0]   awaddr;
  logic [7:0]           awlen;
  logic [2:0]           awsize;
  logic [1:0]           awburst;
  logic                 wvalid;
  logic                 wready;
  logic [DATA_WD-1:0]   wdata;
  logic [DATA_WD/8-1:0] wstrb;
  logic                 wlast;
  logic                 bvalid;
  logic                 bready;
  logic [1:0]           bresp;
  logic                 done_pulse;
  logic                 done_err;

  modport master (
    input  cmd_valid, cmd_dst_addr, cmd_len, data_valid, data, data_last,
           awready, wready, bvalid, bresp,
    output cmd_ready, data_ready, awvalid, awaddr, awlen, awsize, awburst,
           wvalid, wdata, wstrb, wlast, bready, done_pulse, done_err
  );

  modport slave (
    output cmd_valid, cmd_dst_addr, cmd_len, data_valid, data, data_last,
           awready, wready, bvalid, bresp,
    input  cmd_ready, data_ready, awvalid, awaddr, awlen, awsize, awburst,
           wvalid, wdata, wstrb, wlast, bready, done_pulse, done_err
  );
endinterface

// File: rtl/dmac_axi_writer.sv
// Single-burst AXI write engine: one command -> one INCR burst -> response
// -> one-cycle done pulse. Data is passed combinationally from the buffer.
module dmac_axi_writer #(
  parameter int ADDR_WD       = 32,
  parameter int DATA_WD       = 32,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic               clk,
  input  logic               rst,
  dmac_axi_writer_if.master  bus
);
  localparam int STRB_WD = DATA_WD / 8;
  localparam int OFF_WD  = $clog2(STRB_WD);
  localparam int OFF_WS  = (OFF_WD == 0) ? 1 : OFF_WD;

  typedef enum logic [2:0] {IDLE, AW, W, B, DONE} state_t;

  state_t               state_q, state_d;
  logic [ADDR_WD-1:0]   addr_q, addr_d;
  logic [8:0]           len_q, len_d;
  logic [8:0]           beat_cnt_q, beat_cnt_d;
  logic                 err_q, err_d;
  logic [OFF_WS-1:0]    off;
  logic [STRB_WD-1:0]   strb_w;
  logic                 last_w;
  logic                 bad_len;

  // Narrow-start bursts: only the first beat masks lanes below the offset.
  assign off    = (OFF_WD == 0) ? '0 : addr_q[OFF_WS-1:0];
  assign last_w = (beat_cnt_q == len_q - 9'd1);
  assign bad_len = (bus.cmd_len == '0) ||
                   (bus.cmd_len > ADDR_WD'(MAX_BURST_LEN));

  for (genvar i = 0; i < STRB_WD; i++) begin : g_strb
    assign strb_w[i] = (beat_cnt_q != '0) || (OFF_WS'(i) >= off);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    len_d          = len_q;
    beat_cnt_d     = beat_cnt_q;
    err_d          = err_q;
    bus.cmd_ready  = 1'b0;
    bus.data_ready = 1'b0;
    bus.awvalid    = 1'b0;
    bus.awaddr     = '0;
    bus.awlen      = '0;
    bus.awsize     = 3'(OFF_WD);
    bus.awburst    = 2'b01;
    bus.wvalid     = 1'b0;
    bus.wdata      = '0;
    bus.wstrb      = '0;
    bus.wlast      = 1'b0;
    bus.bready     = 1'b0;
    bus.done_pulse = 1'b0;
    bus.done_err   = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          addr_d     = bus.cmd_dst_addr;
          len_d      = bus.cmd_len[8:0];
          beat_cnt_d = '0;
          err_d      = bad_len;
          state_d    = bad_len ? DONE : AW;
        end
      end
      AW: begin
        bus.awvalid = 1'b1;
        bus.awaddr  = addr_q;
        bus.awlen   = 8'(len_q - 9'd1);
        if (bus.awready) state_d = W;
      end
      W: begin
        bus.wvalid     = bus.data_valid;
        bus.data_ready = bus.wready;
        bus.wdata      = bus.data;
        bus.wstrb      = strb_w;
        bus.wlast      = last_w;
        // Beat count follows len; a misplaced data_last only flags an error.
        if (bus.data_valid && bus.wready) begin
          beat_cnt_d = beat_cnt_q + 9'd1;
          if (bus.data_last != last_w) err_d = 1'b1;
          if (last_w) state_d = B;
        end
      end
      B: begin
        bus.bready = 1'b1;
        if (bus.bvalid) begin
          if (bus.bresp != 2'b00) err_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        bus.done_pulse = 1'b1;
        bus.done_err   = err_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
